// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle RV32I controller: opcodes, FSM states and the
// datapath mux/ALU-control codes seen by the ALU-control block and datapath muxes.
package ctrl_pkg;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_S   = 7'b0100011;
  localparam logic [6:0] OP_B   = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_LUI = 7'b0110111;

  typedef enum logic [3:0] {
    StRst,
    StFetch,
    StDecode,
    StMaddr,
    StMrd,
    StLdwb,
    StMwr,
    StExr,
    StExi,
    StAluwb,
    StBr,
    StJal,
    StLuiwb,
    StTrap
  } state_e;

  typedef enum logic [2:0] {
    ClsLoad,
    ClsStore,
    ClsRType,
    ClsIType,
    ClsBranch,
    ClsJal,
    ClsLui,
    ClsIllegal
  } opclass_e;

  typedef enum logic [1:0] {
    SrcAPc    = 2'b00,
    SrcARs1   = 2'b01,
    SrcAOldPc = 2'b10
  } alu_src_a_e;

  typedef enum logic [1:0] {
    SrcBRs2  = 2'b00,
    SrcBFour = 2'b01,
    SrcBImm  = 2'b10
  } alu_src_b_e;

  typedef enum logic [1:0] {
    AluOpAdd    = 2'b00,
    AluOpBranch = 2'b01,
    AluOpRFunct = 2'b10,
    AluOpIFunct = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    WbAluOut = 2'b00,
    WbMdr    = 2'b01,
    WbPc     = 2'b10,
    WbImm    = 2'b11
  } wb_sel_e;

endpackage

// File: rtl/multicycle_control_if.sv
// Controller <-> datapath/memory bundle: opcode and status in, enables and mux selects out.
interface multicycle_control_if;

  logic [6:0] opcode;
  logic       brTaken;
  logic       memReady;

  logic       memReq;
  logic       memWe;
  logic       iOrD;
  logic       irWrite;
  logic       mdrWrite;
  logic       pcWrite;
  logic       pcSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic       regWrite;
  logic [1:0] wbSel;
  logic       instRet;
  logic       illegal;
  logic       busErr;

  modport master (
    input  opcode, brTaken, memReady,
    output memReq, memWe, iOrD, irWrite, mdrWrite, pcWrite, pcSrc,
    output ALUSrcA, ALUSrcB, ALUOp, regWrite, wbSel, instRet, illegal, busErr
  );

  modport slave (
    output opcode, brTaken, memReady,
    input  memReq, memWe, iOrD, irWrite, mdrWrite, pcWrite, pcSrc,
    input  ALUSrcA, ALUSrcB, ALUOp, regWrite, wbSel, instRet, illegal, busErr
  );

endinterface

// File: rtl/opcode_class_decode.sv
// Combinational RV32I opcode classifier for the subset the controller sequences.
module opcode_class_decode
  import ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output opclass_e   opclass,
  output logic       legal
);

  always_comb begin
    opclass = ClsIllegal;
    legal   = 1'b1;
    unique case (opcode)
      OP_LD:   opclass = ClsLoad;
      OP_S:    opclass = ClsStore;
      OP_R:    opclass = ClsRType;
      OP_IMM:  opclass = ClsIType;
      OP_B:    opclass = ClsBranch;
      OP_JAL:  opclass = ClsJal;
      OP_LUI:  opclass = ClsLui;
      default: begin
        opclass = ClsIllegal;
        legal   = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback over a
// shared memory port with a req/ready handshake and an optional wait-cycle timeout.
module multicycle_control #(
  parameter int unsigned MEM_TIMEOUT = 0,
  parameter int unsigned TO_W        = 8
) (
  input logic                 clk,
  input logic                 rst_n,
  multicycle_control_if.master bus
);

  import ctrl_pkg::*;

  state_e          state_q, state_d;
  logic [TO_W-1:0] wait_q, wait_d;
  logic            illegal_q, illegal_d;
  logic            bus_err_q, bus_err_d;

  opclass_e opclass;
  logic     legal;
  logic     mem_wait;
  logic     timeout_hit;

  opcode_class_decode u_decode (
    .opcode  (bus.opcode),
    .opclass (opclass),
    .legal   (legal)
  );

  assign mem_wait    = ((state_q == StFetch) || (state_q == StMrd) || (state_q == StMwr)) &&
                       !bus.memReady;
  assign timeout_hit = (MEM_TIMEOUT != 0) && mem_wait && (wait_q == TO_W'(MEM_TIMEOUT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StRst;
      wait_q    <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    bus_err_d = bus_err_q;
    // Counter only runs while a memory state is stalled; any exit leaves it cleared.
    wait_d    = '0;
    if ((MEM_TIMEOUT != 0) && mem_wait && !timeout_hit) begin
      wait_d = wait_q + TO_W'(1);
    end

    unique case (state_q)
      StRst:   state_d = StFetch;
      StFetch: begin
        if (timeout_hit) begin
          state_d   = StTrap;
          bus_err_d = 1'b1;
        end else if (bus.memReady) begin
          state_d = StDecode;
        end
      end
      StDecode: begin
        if (!legal) begin
          state_d   = StTrap;
          illegal_d = 1'b1;
        end else begin
          unique case (opclass)
            ClsLoad, ClsStore: state_d = StMaddr;
            ClsRType:          state_d = StExr;
            ClsIType:          state_d = StExi;
            ClsBranch:         state_d = StBr;
            ClsJal:            state_d = StJal;
            ClsLui:            state_d = StLuiwb;
            default: begin
              state_d   = StTrap;
              illegal_d = 1'b1;
            end
          endcase
        end
      end
      StMaddr: state_d = (opclass == ClsStore) ? StMwr : StMrd;
      StMrd: begin
        if (timeout_hit) begin
          state_d   = StTrap;
          bus_err_d = 1'b1;
        end else if (bus.memReady) begin
          state_d = StLdwb;
        end
      end
      StMwr: begin
        if (timeout_hit) begin
          state_d   = StTrap;
          bus_err_d = 1'b1;
        end else if (bus.memReady) begin
          state_d = StFetch;
        end
      end
      StExr, StExi:                            state_d = StAluwb;
      StLdwb, StAluwb, StBr, StJal, StLuiwb:   state_d = StFetch;
      StTrap:                                  state_d = StTrap;
      default:                                 state_d = StRst;
    endcase
  end

  always_comb begin
    bus.memReq   = 1'b0;
    bus.memWe    = 1'b0;
    bus.iOrD     = 1'b0;
    bus.irWrite  = 1'b0;
    bus.mdrWrite = 1'b0;
    bus.pcWrite  = 1'b0;
    bus.pcSrc    = 1'b0;
    bus.ALUSrcA  = SrcAPc;
    bus.ALUSrcB  = SrcBRs2;
    bus.ALUOp    = AluOpAdd;
    bus.regWrite = 1'b0;
    bus.wbSel    = WbAluOut;
    bus.instRet  = 1'b0;
    bus.illegal  = illegal_q;
    bus.busErr   = bus_err_q;

    unique case (state_q)
      StFetch: begin
        bus.memReq  = 1'b1;
        bus.ALUSrcB = SrcBFour;
        bus.irWrite = bus.memReady;
        bus.pcWrite = bus.memReady;
      end
      StDecode: begin
        bus.ALUSrcA = SrcAOldPc;
        bus.ALUSrcB = SrcBImm;
      end
      StMaddr: begin
        bus.ALUSrcA = SrcARs1;
        bus.ALUSrcB = SrcBImm;
      end
      StMrd: begin
        bus.memReq   = 1'b1;
        bus.iOrD     = 1'b1;
        bus.mdrWrite = bus.memReady;
      end
      StLdwb: begin
        bus.regWrite = 1'b1;
        bus.wbSel    = WbMdr;
        bus.instRet  = 1'b1;
      end
      StMwr: begin
        bus.memReq  = 1'b1;
        bus.iOrD    = 1'b1;
        bus.memWe   = 1'b1;
        bus.instRet = bus.memReady;
      end
      StExr: begin
        bus.ALUSrcA = SrcARs1;
        bus.ALUOp   = AluOpRFunct;
      end
      StExi: begin
        bus.ALUSrcA = SrcARs1;
        bus.ALUSrcB = SrcBImm;
        bus.ALUOp   = AluOpIFunct;
      end
      StAluwb: begin
        bus.regWrite = 1'b1;
        bus.instRet  = 1'b1;
      end
      StBr: begin
        bus.ALUSrcA = SrcARs1;
        bus.ALUOp   = AluOpBranch;
        bus.pcSrc   = 1'b1;
        bus.pcWrite = bus.brTaken;
        bus.instRet = 1'b1;
      end
      StJal: begin
        bus.regWrite = 1'b1;
        bus.wbSel    = WbPc;
        bus.pcWrite  = 1'b1;
        bus.pcSrc    = 1'b1;
        bus.instRet  = 1'b1;
      end
      StLuiwb: begin
        bus.regWrite = 1'b1;
        bus.wbSel    = WbImm;
        bus.instRet  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore/Mealy FSM that sequences the non-pipelined RV32I datapath over multiple cycles: fetch, decode, execute, memory, writeback.
- Replaces single-cycle opcode decode, so the ALU, register file and one shared instruction/data memory port are reused across states.
- Drives all datapath enables and muxes, and handles a req/ready handshake to the shared memory.

Parameters:
- OP_R, 7'b0110011, R-type opcode.
- OP_LD, 7'b0000011, load opcode.
- OP_IMM, 7'b0010011, I-type ALU opcode.
- OP_S, 7'b0100011, store opcode.
- OP_B, 7'b1100011, branch opcode.
- OP_JAL, 7'b1101111, JAL opcode.
- OP_LUI, 7'b0110111, LUI opcode.
- MEM_TIMEOUT, 0, maximum memory wait cycles; 0 disables the timeout.
- TO_W, 8, width of the wait counter; must satisfy MEM_TIMEOUT < 2^TO_W.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  7  IR[6:0]; valid from DECODE onward.
- brTaken  in  1  ALU compare result for the current branch.
- memReady  in  1  memory completes the current request this cycle.
- memReq  out  1  memory request.
- memWe  out  1  request is a write.
- iOrD  out  1  address select: 0 = PC, 1 = ALUOut.
- irWrite  out  1  load IR from memory read data.
- mdrWrite  out  1  load MDR from memory read data.
- pcWrite  out  1  PC register enable.
- pcSrc  out  1  PC source: 0 = ALU result, 1 = ALUOut register.
- ALUSrcA  out  2  00 = PC, 01 = rs1, 10 = oldPC.
- ALUSrcB  out  2  00 = rs2, 01 = const 4, 10 = imm.
- ALUOp  out  2  00 = add, 01 = branch compare, 10 = R funct decode, 11 = I funct decode.
- regWrite  out  1  register-file write enable.
- wbSel  out  2  writeback source: 00 = ALUOut, 01 = MDR, 10 = PC, 11 = imm.
- instRet  out  1  one-cycle pulse per retired instruction.
- illegal  out  1  sticky: illegal opcode.
- busErr  out  1  sticky: memory timeout.

Behaviour:
- Reset: rst_n low forces state RST immediately. In RST every output is 0. Unless stated otherwise, an output is 0 in any state that does not assert it.
- RST -> FETCH on the first clk after rst_n rises.
- FETCH:
  - Asserts memReq=1, iOrD=0, ALUSrcA=00, ALUSrcB=01, ALUOp=00.
  - irWrite and pcWrite equal memReady (Mealy).
  - On memReady, go to DECODE; otherwise hold.
- DECODE:
  - Asserts ALUSrcA=10, ALUSrcB=10, ALUOp=00, which computes the branch/jump target into ALUOut.
  - Next state by opcode: LD or S -> MADDR; R -> EXR; IMM -> EXI; B -> BR; JAL -> JAL; LUI -> LUIWB; any other -> TRAP with illegal set.
- MADDR: ALUSrcA=01, ALUSrcB=10, ALUOp=00. Next is MRD for a load, MWR for a store.
- MRD:
  - Asserts memReq=1, iOrD=1, memWe=0.
  - mdrWrite equals memReady.
  - On memReady, go to LDWB.
- LDWB: regWrite=1, wbSel=01, instRet=1, then FETCH.
- MWR: memReq=1, iOrD=1, memWe=1. On memReady: instRet=1, go to FETCH.
- EXR: ALUSrcA=01, ALUSrcB=00, ALUOp=10, then ALUWB.
- EXI: ALUSrcA=01, ALUSrcB=10, ALUOp=11, then ALUWB.
- ALUWB: regWrite=1, wbSel=00, instRet=1, then FETCH.
- BR: ALUSrcA=01, ALUSrcB=00, ALUOp=01, pcSrc=1, pcWrite equal to brTaken, instRet=1, then FETCH.
- JAL: regWrite=1, wbSel=10 (PC already holds the link address), pcWrite=1, pcSrc=1, instRet=1, then FETCH.
- LUIWB: regWrite=1, wbSel=11, instRet=1, then FETCH.
- TRAP: all outputs 0 except the sticky flags. Exits only via reset.
- Latencies (N = wait cycles before memReady in each memory state):
  - R, IMM: 4+N cycles.
  - LD: 5+2N cycles.
  - S: 4+2N cycles.
  - B, JAL, LUI: 3+N cycles.
- Handshake:
  - memReq and its qualifiers stay constant until memReady.
  - memReady in the first cycle of a request is legal (zero-wait).
  - memReady while memReq=0 is ignored.
- Timeout:
  - When MEM_TIMEOUT>0, a wait counter increments in FETCH, MRD and MWR while memReady=0, and clears on state exit.
  - When the counter equals MEM_TIMEOUT with memReady still 0, go to TRAP and set busErr.
- Reset mid-operation: memReq drops asynchronously with reset; no partial register or PC write occurs.

Decomposition:
- Package ctrl_pkg holds:
  - opcode constants;
  - state encoding;
  - ALUSrcA/ALUSrcB/ALUOp/wbSel encodings, shared with the ALU-control and datapath muxes.
- One natural sub-module, opcode_class_decode: combinational opcode -> class enum, plus a legal flag.
- FSM register, wait counter and output decode remain in multicycle_control.

Test Plan:
- Zero-wait R instruction: after reset release, memReady=1 in FETCH, opcode=0110011 -> states FETCH, DECODE, EXR, ALUWB. regWrite=1, wbSel=00 and instRet=1 occur in cycle 4, then FETCH.
- Load with 2 wait states: memReady low for 2 cycles in each of FETCH and MRD, opcode=0000011 -> mdrWrite pulses exactly once, LDWB has wbSel=01, total 9 cycles.
- Branch: opcode=1100011 with brTaken=1, then again with brTaken=0 -> pcWrite=1 and pcSrc=1 in BR for the taken case; pcWrite=0 for the not-taken case; both return to FETCH.
- Illegal opcode 0000000 -> TRAP after DECODE, illegal=1, memReq stays 0 for 20 cycles; rst_n low clears the flag and reaches RST.
- Timeout: MEM_TIMEOUT=3, memReady held 0 in FETCH -> busErr=1 after 3 wait cycles, state TRAP.
- Async reset asserted mid-MRD with memReq=1 -> memReq=0 in the same cycle, with no clock edge required; FETCH follows one cycle after rst_n rises.
